// File: rtl/scie_result_queue.sv
// Result capture queue for the SCIE complex-arithmetic unit.
// Credit-gates result reads so a captured sample always has a FIFO slot.
module scie_result_queue #(
    parameter int         LATENCY     = 1,
    parameter int         DEPTH       = 4,
    parameter logic [6:0] READ_OPCODE = 7'h5B
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [31:0] issue_insn,
    output logic        issue_stall,
    output logic        scie_valid,
    input  logic [15:0] io_rd_real,
    input  logic [15:0] io_rd_imag,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [4:0]  occupancy
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [LATENCY-1:0] tag_v;
    logic [4:0]         tag_rd [LATENCY];

    logic [31:0]   data_mem [DEPTH];
    logic [4:0]    rd_mem   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    fifo_count;
    logic [4:0]    inflight_count;

    logic is_read;
    logic credit_ok;
    logic accept;
    logic capture;
    logic pop;

    // Credits come from registered counts only; a pop frees its slot next cycle.
    assign occupancy   = fifo_count + inflight_count;
    assign is_read     = issue_valid && (issue_insn[6:0] == READ_OPCODE);
    assign credit_ok   = occupancy < DEPTH_C;
    assign issue_stall = is_read && !credit_ok;
    assign scie_valid  = issue_valid && !issue_stall;
    assign accept      = is_read && !issue_stall;

    assign capture  = tag_v[LATENCY-1];
    assign wb_valid = (fifo_count != 5'd0);
    assign pop      = wb_valid && wb_ready;
    assign wb_data  = data_mem[rd_ptr];
    assign wb_rd    = rd_mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_rd[i] <= '0;
            end
        end else begin
            tag_v[0]  <= accept;
            tag_rd[0] <= issue_insn[11:7];
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_rd[i] <= tag_rd[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                rd_mem[i]   <= '0;
            end
            wr_ptr <= '0;
        end else if (capture) begin
            data_mem[wr_ptr] <= {io_rd_imag, io_rd_real};
            rd_mem[wr_ptr]   <= tag_rd[LATENCY-1];
            wr_ptr           <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Accept, capture and pop may coincide; each count nets them in one update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fifo_count     <= '0;
            inflight_count <= '0;
        end else begin
            fifo_count     <= fifo_count + 5'(capture) - 5'(pop);
            inflight_count <= inflight_count + 5'(accept) - 5'(capture);
        end
    end

endmodule

// File: tb/tb_scie_result_queue.sv
// Directed table-driven bench for scie_result_queue.
// Main instance uses LATENCY=1; a second instance covers LATENCY=2.
module tb_scie_result_queue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_insn = '0;
    logic [15:0] io_rd_real = '0;
    logic [15:0] io_rd_imag = '0;
    logic        wb_ready = 1'b0;

    logic        issue_stall, scie_valid, wb_valid;
    logic [4:0]  wb_rd, occupancy;
    logic [31:0] wb_data;

    logic        issue_stall2, scie_valid2, wb_valid2;
    logic [4:0]  wb_rd2, occupancy2;
    logic [31:0] wb_data2;

    int applied = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    scie_result_queue #(.LATENCY(1), .DEPTH(4), .READ_OPCODE(7'h5B)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_insn(issue_insn),
        .issue_stall(issue_stall), .scie_valid(scie_valid),
        .io_rd_real(io_rd_real), .io_rd_imag(io_rd_imag),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .occupancy(occupancy)
    );

    scie_result_queue #(.LATENCY(2), .DEPTH(4), .READ_OPCODE(7'h5B)) dut2 (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_insn(issue_insn),
        .issue_stall(issue_stall2), .scie_valid(scie_valid2),
        .io_rd_real(io_rd_real), .io_rd_imag(io_rd_imag),
        .wb_valid(wb_valid2), .wb_ready(wb_ready),
        .wb_rd(wb_rd2), .wb_data(wb_data2), .occupancy(occupancy2)
    );

    typedef struct {
        logic        iv;
        logic [31:0] insn;
        logic        rdy;
        logic [15:0] re;
        logic [15:0] im;
        logic        e_stall;
        logic        e_sv;
        logic        e_wbv;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [4:0]  e_occ;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(logic iv, logic [31:0] insn, logic rdy,
                                logic [15:0] re, logic [15:0] im,
                                logic st, logic sv, logic wbv,
                                logic [4:0] rd, logic [31:0] data,
                                logic [4:0] occ);
        vec_t v;
        v.iv = iv; v.insn = insn; v.rdy = rdy; v.re = re; v.im = im;
        v.e_stall = st; v.e_sv = sv; v.e_wbv = wbv;
        v.e_rd = rd; v.e_data = data; v.e_occ = occ;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s (step %0d): got %h, want %h", nm, idx, got, exp);
        end
    endtask

    // A capture into a full FIFO would lose data.
    always @(posedge clock) begin
        if (!reset && dut.capture && dut.fifo_count == 5'd4) begin
            miscompares++;
            $display("FAIL overflow: capture with fifo_count=%0d", dut.fifo_count);
        end
    end

    localparam logic [31:0] R1 = 32'h0000_00DB;
    localparam logic [31:0] R2 = 32'h0000_015B;
    localparam logic [31:0] R3 = 32'h0000_01DB;
    localparam logic [31:0] R4 = 32'h0000_025B;
    localparam logic [31:0] R5 = 32'h0000_02DB;
    localparam logic [31:0] R7 = 32'h0000_03DB;

    initial begin
        #2;
        chk("rst_wb_valid", 0, 32'(wb_valid), 0);
        chk("rst_wb_rd", 0, 32'(wb_rd), 0);
        chk("rst_wb_data", 0, wb_data, 0);
        chk("rst_occ", 0, 32'(occupancy), 0);
        chk("rst_occ2", 0, 32'(occupancy2), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Single read: rd=2, result (-552, 60)
        tab.push_back(mk(1, R2, 1, 16'h0, 16'h0, 0, 1, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 16'hFDD8, 16'h003C, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(0, 0, 1, 16'h0, 16'h0, 0, 0, 1, 2, 32'h003CFDD8, 1));
        tab.push_back(mk(0, 0, 1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0));
        // Back-to-back reads with wb_ready low
        tab.push_back(mk(1, R1, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0, 0));
        tab.push_back(mk(1, R2, 0, 16'h0101, 16'h0A01, 0, 1, 0, 0, 0, 1));
        tab.push_back(mk(1, R3, 0, 16'h0102, 16'h0A02, 0, 1, 1, 1, 32'h0A010101, 2));
        tab.push_back(mk(1, R4, 0, 16'h0103, 16'h0A03, 0, 1, 1, 1, 32'h0A010101, 3));
        tab.push_back(mk(1, R5, 0, 16'h0104, 16'h0A04, 1, 0, 1, 1, 32'h0A010101, 4));
        tab.push_back(mk(1, R5, 0, 16'hDEAD, 16'hDEAD, 1, 0, 1, 1, 32'h0A010101, 4));
        // Non-read passthrough while full
        tab.push_back(mk(1, 32'h0B, 0, 16'hDEAD, 16'hDEAD, 0, 1, 1, 1, 32'h0A010101, 4));
        tab.push_back(mk(1, 32'h2B, 0, 16'hDEAD, 16'hDEAD, 0, 1, 1, 1, 32'h0A010101, 4));
        // Pop frees a credit only on the following cycle
        tab.push_back(mk(1, R5, 1, 16'hDEAD, 16'hDEAD, 1, 0, 1, 1, 32'h0A010101, 4));
        tab.push_back(mk(1, R5, 0, 16'hDEAD, 16'hDEAD, 0, 1, 1, 2, 32'h0A020102, 3));
        // Capture and pop together at full: (-478, -1029)
        tab.push_back(mk(0, 0, 1, 16'hFE22, 16'hFBFB, 0, 0, 1, 2, 32'h0A020102, 4));
        tab.push_back(mk(0, 0, 1, 16'h0, 16'h0, 0, 0, 1, 3, 32'h0A030103, 3));
        tab.push_back(mk(0, 0, 1, 16'h0, 16'h0, 0, 0, 1, 4, 32'h0A040104, 2));
        tab.push_back(mk(0, 0, 1, 16'h0, 16'h0, 0, 0, 1, 5, 32'hFBFBFE22, 1));
        tab.push_back(mk(0, 0, 1, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tab.size(); i++) begin
            issue_valid = tab[i].iv;
            issue_insn  = tab[i].insn;
            wb_ready    = tab[i].rdy;
            io_rd_real  = tab[i].re;
            io_rd_imag  = tab[i].im;
            #1;
            chk("issue_stall", i, 32'(issue_stall), 32'(tab[i].e_stall));
            chk("scie_valid", i, 32'(scie_valid), 32'(tab[i].e_sv));
            chk("wb_valid", i, 32'(wb_valid), 32'(tab[i].e_wbv));
            chk("occupancy", i, 32'(occupancy), 32'(tab[i].e_occ));
            if (tab[i].e_wbv) begin
                chk("wb_rd", i, 32'(wb_rd), 32'(tab[i].e_rd));
                chk("wb_data", i, wb_data, tab[i].e_data);
            end
            @(negedge clock);
        end

        // Reset mid-flight
        issue_valid = 1; issue_insn = R3; wb_ready = 0;
        @(negedge clock);
        issue_insn = R4; io_rd_real = 16'h0005; io_rd_imag = 16'h0006;
        @(negedge clock);
        issue_valid = 0;
        #1;
        chk("pre_rst_wb_valid", 100, 32'(wb_valid), 1);
        chk("pre_rst_occ", 100, 32'(occupancy), 2);
        reset = 1; issue_valid = 1; issue_insn = R2;
        #1;
        chk("mid_rst_wb_valid", 101, 32'(wb_valid), 0);
        chk("mid_rst_occ", 101, 32'(occupancy), 0);
        chk("mid_rst_wb_rd", 101, 32'(wb_rd), 0);
        chk("mid_rst_wb_data", 101, wb_data, 0);
        chk("mid_rst_scie_valid", 101, 32'(scie_valid), 1);
        chk("mid_rst_stall", 101, 32'(issue_stall), 0);
        @(negedge clock);
        reset = 0; issue_valid = 0;
        io_rd_real = 16'h7777; io_rd_imag = 16'h8888;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_wb_valid", 102 + i, 32'(wb_valid), 0);
            chk("post_rst_occ", 102 + i, 32'(occupancy), 0);
        end

        // LATENCY=2: accept at N, capture at N+2, wb_valid at N+3
        issue_valid = 1; issue_insn = R7; wb_ready = 0;
        io_rd_real = 0; io_rd_imag = 0;
        #1;
        chk("l2_stall", 200, 32'(issue_stall2), 0);
        @(negedge clock);
        issue_valid = 0; io_rd_real = 16'h1111; io_rd_imag = 16'h2222;
        #1;
        chk("l2_n1_wb_valid", 201, 32'(wb_valid2), 0);
        chk("l2_n1_occ", 201, 32'(occupancy2), 1);
        @(negedge clock);
        io_rd_real = 16'h0123; io_rd_imag = 16'h0456;
        #1;
        chk("l2_n2_wb_valid", 202, 32'(wb_valid2), 0);
        chk("l2_n2_occ", 202, 32'(occupancy2), 1);
        @(negedge clock);
        io_rd_real = 16'h9999; io_rd_imag = 16'h9999;
        #1;
        chk("l2_n3_wb_valid", 203, 32'(wb_valid2), 1);
        chk("l2_n3_wb_rd", 203, 32'(wb_rd2), 7);
        chk("l2_n3_wb_data", 203, wb_data2, 32'h04560123);
        chk("l2_n3_occ", 203, 32'(occupancy2), 1);
        @(negedge clock);
        wb_ready = 1;
        #1;
        chk("l2_hold_wb_data", 204, wb_data2, 32'h04560123);
        @(negedge clock);
        wb_ready = 0;
        #1;
        chk("l2_drain_wb_valid", 205, 32'(wb_valid2), 0);
        chk("l2_drain_occ", 205, 32'(occupancy2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
